// File: rtl/dvma_cycle_sequencer.sv
// DVMA cycle sequencer: bus request/grant, wait-state pacing and c_s7 strobe for the U212 decoder.
// Optional grant timeout with WAITDROP recovery when DVMA_GRANT_TIMEOUT_EN is defined.
module dvma_cycle_sequencer #(
    parameter int WAIT_STATES   = 7,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic xreq,
    input  logic p1_mrdc,
    input  logic p1_mrwc,
    input  logic cpu_as_n,
    input  logic cpu_bg_n,
    output logic cpu_br_n,
    output logic cpu_bgack_n,
    output logic xen_n,
    output logic c_s7,
    output logic dvma_busy,
    output logic timeout_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_GRANT    = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_REL      = 3'd5;
`ifdef DVMA_GRANT_TIMEOUT_EN
    localparam logic [2:0] S_WAITDROP = 3'd6;
    localparam logic [7:0] TMO_LAST   = 8'(GRANT_TIMEOUT - 1);
`endif
    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_STATES - 1);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("dvma_cycle_sequencer: WAIT_STATES must be 1..15");
    end
    if (GRANT_TIMEOUT < 1 || GRANT_TIMEOUT > 255) begin : g_bad_grant_timeout
        $error("dvma_cycle_sequencer: GRANT_TIMEOUT must be 1..255");
    end

    logic [1:0] xreq_sync_q;
    logic [1:0] mrdc_sync_q;
    logic [1:0] mrwc_sync_q;
    logic       xreq_s;
    logic       mrdc_s;
    logic       mrwc_s;

    logic [2:0] state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    logic br_n_q, br_n_d;
    logic bgack_n_q, bgack_n_d;
    logic xen_n_q, xen_n_d;
    logic c_s7_q, c_s7_d;
    logic busy_q, busy_d;

    assign xreq_s = xreq_sync_q[1];
    assign mrdc_s = mrdc_sync_q[1];
    assign mrwc_s = mrwc_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xreq_sync_q <= 2'b00;
            mrdc_sync_q <= 2'b00;
            mrwc_sync_q <= 2'b00;
        end else begin
            xreq_sync_q <= {xreq_sync_q[0], xreq};
            mrdc_sync_q <= {mrdc_sync_q[0], p1_mrdc};
            mrwc_sync_q <= {mrwc_sync_q[0], p1_mrwc};
        end
    end

`ifdef DVMA_GRANT_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_err_q, tmo_err_d;
`endif

    // Bus handshake: BR is held low in REQ until BG is low with AS high (CPU cycle
    // finished); BGACK then owns the bus from GRANT through REL.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
`ifdef DVMA_GRANT_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (xreq_s) begin
                    state_d = S_REQ;
`ifdef DVMA_GRANT_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end
            end
            S_REQ: begin
`ifdef DVMA_GRANT_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                if (!xreq_s) begin
                    state_d = S_IDLE;
                end else if (!cpu_bg_n && cpu_as_n) begin
                    state_d = S_GRANT;
`ifdef DVMA_GRANT_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_WAITDROP;
`endif
                end
            end
            S_GRANT: begin
                wait_cnt_d = 4'd0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (!xreq_s) begin
                    state_d = S_REL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!(mrdc_s || mrwc_s)) begin
                    state_d = S_REL;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
`ifdef DVMA_GRANT_TIMEOUT_EN
            S_WAITDROP: begin
                if (!xreq_s) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered so they change with the state.
    always_comb begin
        br_n_d    = (state_d != S_REQ);
        bgack_n_d = !((state_d == S_GRANT) || (state_d == S_RUN) ||
                      (state_d == S_ACK)   || (state_d == S_REL));
        xen_n_d   = !((state_d == S_GRANT) || (state_d == S_RUN) || (state_d == S_ACK));
        c_s7_d    = (state_d == S_ACK);
        busy_d    = (state_d != S_IDLE);
`ifdef DVMA_GRANT_TIMEOUT_EN
        tmo_err_d = (state_q == S_REQ) && (state_d == S_WAITDROP);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            br_n_q     <= 1'b1;
            bgack_n_q  <= 1'b1;
            xen_n_q    <= 1'b1;
            c_s7_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            br_n_q     <= br_n_d;
            bgack_n_q  <= bgack_n_d;
            xen_n_q    <= xen_n_d;
            c_s7_q     <= c_s7_d;
            busy_q     <= busy_d;
        end
    end

`ifdef DVMA_GRANT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign cpu_br_n    = br_n_q;
    assign cpu_bgack_n = bgack_n_q;
    assign xen_n       = xen_n_q;
    assign c_s7        = c_s7_q;
    assign dvma_busy   = busy_q;

endmodule
